// File: rtl/nv_nvdla_dmaif_rdreq.sv
// ---------------------------------------------------------------------------
// nv_nvdla_dmaif_rdreq
//
// Read-request side of the DMA interface. A single client request stream is
// buffered in a 2-entry skid and dispatched in order to either the mcif or
// the cvif request port, based on the ram_type that travels with each
// request. The block counts outstanding response beats so the return-path
// buffer (CREDIT beats deep) can never overflow. A lock FSM makes sure that
// only one target has responses in flight at a time, which lets the
// response merge simply OR the two return paths together.
//
// Handshake semantics (all ports): a transfer happens on a rising clock edge
// where valid (pvld) and ready (prdy) are both high. Once valid is raised
// it stays high, with pd unchanged, until that transfer happens. ready may
// change freely and never depends combinationally on valid of the same port.
//
// Ports
//   nvdla_core_clk         clock
//   nvdla_core_rst         asynchronous active-high reset
//   dmaif_rd_req_pd        client request {size, addr}; size = beats - 1
//   dmaif_rd_req_ram_type  1 = mcif, 0 = cvif (qualified by pvld)
//   dmaif_rd_req_pvld      client request valid
//   dmaif_rd_req_prdy      client request ready (registered, "skid not full")
//   mcif_rd_req_pd/valid   request to mcif, ready comes back on _ready
//   cvif_rd_req_pd/valid   request to cvif, ready comes back on _ready
//   dmaif_rd_rsp_beat      one response beat consumed by the client
//   rd_outstanding         current outstanding-beat count
//   dbg_lock_state         lock FSM state: 0 = NONE, 1 = MC, 2 = CV
// ---------------------------------------------------------------------------
module nv_nvdla_dmaif_rdreq #(
    parameter int ADDR_W = 64,
    parameter int SIZE_W = 13,
    parameter int CREDIT = 64,
    parameter int CNT_W  = 7
) (
    input  logic                     nvdla_core_clk,
    input  logic                     nvdla_core_rst,
    input  logic [ADDR_W+SIZE_W-1:0] dmaif_rd_req_pd,
    input  logic                     dmaif_rd_req_ram_type,
    input  logic                     dmaif_rd_req_pvld,
    output logic                     dmaif_rd_req_prdy,
    output logic [ADDR_W+SIZE_W-1:0] mcif_rd_req_pd,
    output logic                     mcif_rd_req_valid,
    input  logic                     mcif_rd_req_ready,
    output logic [ADDR_W+SIZE_W-1:0] cvif_rd_req_pd,
    output logic                     cvif_rd_req_valid,
    input  logic                     cvif_rd_req_ready,
    input  logic                     dmaif_rd_rsp_beat,
    output logic [CNT_W-1:0]         rd_outstanding,
    output logic [1:0]               dbg_lock_state
);

    localparam int PD_W  = ADDR_W + SIZE_W;
    localparam int SUM_W = ((CNT_W > SIZE_W + 1) ? CNT_W : SIZE_W + 1) + 1;

    typedef enum logic [1:0] {
        LOCK_NONE = 2'd0,
        LOCK_MC   = 2'd1,
        LOCK_CV   = 2'd2
    } lock_e;

    // ---------------- state ----------------
    logic [PD_W:0]      skid0_q, skid1_q;     // {ram_type, pd}
    logic               wr_ptr_q, rd_ptr_q;
    logic [1:0]         skid_cnt_q, skid_cnt_d;
    logic               prdy_q, prdy_d;

    logic               mc_valid_q, mc_valid_d;
    logic [PD_W-1:0]    mc_pd_q, mc_pd_d;
    logic               cv_valid_q, cv_valid_d;
    logic [PD_W-1:0]    cv_pd_q, cv_pd_d;

    logic [CNT_W-1:0]   rd_cnt_q, rd_cnt_d;
    lock_e              lock_q, lock_d;

    // ---------------- combinational ----------------
    logic               push, pop;
    logic               head_vld;
    logic [PD_W:0]      head;
    logic               head_mc;
    logic [SIZE_W:0]    head_n;
    logic [SUM_W-1:0]   need_sum;
    logic               credit_ok;
    logic               mc_free, cv_free;
    logic               disp_mc, disp_cv, dispatch;
    logic               cnt_dec;
    logic [CNT_W-1:0]   cnt_add;

    always_comb begin
        push       = dmaif_rd_req_pvld && prdy_q;
        head_vld   = (skid_cnt_q != 2'd0);
        head       = rd_ptr_q ? skid1_q : skid0_q;
        head_mc    = head[PD_W];
        head_n     = {1'b0, head[PD_W-1:ADDR_W]} + {{SIZE_W{1'b0}}, 1'b1};

        // Wide enough that cnt + n cannot wrap before the compare.
        need_sum   = SUM_W'(rd_cnt_q) + SUM_W'(head_n);
        credit_ok  = (need_sum <= SUM_W'(CREDIT));

        mc_free    = !mc_valid_q || mcif_rd_req_ready;
        cv_free    = !cv_valid_q || cvif_rd_req_ready;

        // The lock only releases once the count is zero, so a target change
        // always waits for the other side to drain completely. The other
        // register must also be free so the two valids can never overlap.
        disp_mc    = head_vld && head_mc && mc_free && cv_free && credit_ok &&
                     (lock_q != LOCK_CV);
        disp_cv    = head_vld && !head_mc && cv_free && mc_free && credit_ok &&
                     (lock_q != LOCK_MC);
        dispatch   = disp_mc || disp_cv;
        pop        = dispatch;

        // Skid occupancy and the registered ready derived from it.
        skid_cnt_d = skid_cnt_q + {1'b0, push} - {1'b0, pop};
        prdy_d     = (skid_cnt_d != 2'd2);

        // Outstanding counter; an illegal beat at zero is ignored (saturate).
        cnt_add    = dispatch ? CNT_W'(head_n) : '0;
        cnt_dec    = dmaif_rd_rsp_beat && (rd_cnt_q != '0);
        rd_cnt_d   = rd_cnt_q + cnt_add - {{(CNT_W-1){1'b0}}, cnt_dec};

        // Output registers: load on dispatch, clear on handshake, else hold.
        mc_valid_d = mc_valid_q;
        mc_pd_d    = mc_pd_q;
        if (disp_mc) begin
            mc_valid_d = 1'b1;
            mc_pd_d    = head[PD_W-1:0];
        end else if (mc_valid_q && mcif_rd_req_ready) begin
            mc_valid_d = 1'b0;
        end

        cv_valid_d = cv_valid_q;
        cv_pd_d    = cv_pd_q;
        if (disp_cv) begin
            cv_valid_d = 1'b1;
            cv_pd_d    = head[PD_W-1:0];
        end else if (cv_valid_q && cvif_rd_req_ready) begin
            cv_valid_d = 1'b0;
        end
    end

    // ---------------- lock FSM next state ----------------
    always_comb begin
        lock_d = lock_q;
        case (lock_q)
            LOCK_NONE: begin
                if (disp_mc) begin
                    lock_d = LOCK_MC;
                end else if (disp_cv) begin
                    lock_d = LOCK_CV;
                end
            end
            LOCK_MC, LOCK_CV: begin
                if (!dispatch && (rd_cnt_d == '0)) begin
                    lock_d = LOCK_NONE;
                end
            end
            default: lock_d = LOCK_NONE;
        endcase
    end

    // ---------------- registers ----------------
    always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
        if (nvdla_core_rst) begin
            skid0_q    <= '0;
            skid1_q    <= '0;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            skid_cnt_q <= 2'd0;
            prdy_q     <= 1'b0;
            mc_valid_q <= 1'b0;
            mc_pd_q    <= '0;
            cv_valid_q <= 1'b0;
            cv_pd_q    <= '0;
            rd_cnt_q   <= '0;
            lock_q     <= LOCK_NONE;
        end else begin
            if (push) begin
                if (wr_ptr_q) begin
                    skid1_q <= {dmaif_rd_req_ram_type, dmaif_rd_req_pd};
                end else begin
                    skid0_q <= {dmaif_rd_req_ram_type, dmaif_rd_req_pd};
                end
                wr_ptr_q <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            skid_cnt_q <= skid_cnt_d;
            prdy_q     <= prdy_d;
            mc_valid_q <= mc_valid_d;
            mc_pd_q    <= mc_pd_d;
            cv_valid_q <= cv_valid_d;
            cv_pd_q    <= cv_pd_d;
            rd_cnt_q   <= rd_cnt_d;
            lock_q     <= lock_d;
        end
    end

    // ---------------- outputs ----------------
    assign dmaif_rd_req_prdy = prdy_q;
    assign mcif_rd_req_valid = mc_valid_q;
    assign mcif_rd_req_pd    = mc_pd_q;
    assign cvif_rd_req_valid = cv_valid_q;
    assign cvif_rd_req_pd    = cv_pd_q;
    assign rd_outstanding    = rd_cnt_q;
    assign dbg_lock_state    = lock_q;

    // ---------------- protocol checks ----------------
    // A response beat with nothing outstanding means the client is broken.
    a_no_beat_underflow: assert property (@(posedge nvdla_core_clk)
        disable iff (nvdla_core_rst)
        !(dmaif_rd_rsp_beat && (rd_cnt_q == '0)));

    // A request larger than the whole credit pool can never be issued.
    a_size_fits_credit: assert property (@(posedge nvdla_core_clk)
        disable iff (nvdla_core_rst)
        !(head_vld && (SUM_W'(head_n) > SUM_W'(CREDIT))));

    a_one_valid: assert property (@(posedge nvdla_core_clk)
        disable iff (nvdla_core_rst)
        !(mc_valid_q && cv_valid_q));

endmodule
